// File: rtl/fpsu_pkg.sv
// Shared constants and types for the FP issue-port op queue.
// Default parameter values, the add-class op bit index and the
// delay-line stage entry layout live here so every file agrees on them.
package fpsu_pkg;

  localparam int NPORT_DEF   = 3;
  localparam int NHALF_DEF   = 2;
  localparam int OPW_DEF     = 21;
  localparam int DEPTH_DEF   = 3;
  localparam int ADD_BIT_DEF = 10;
  localparam int RETW_DEF    = 14;

  // inflight counter width per port; holds up to the deepest legal delay line (8)
  localparam int CNT_W = 4;

  // One delay-line stage at the default op width: valid flag, subtract
  // variant flag, and the op word (stored as zero whenever valid is low).
  typedef struct packed {
    logic               valid;
    logic               xsub;
    logic [OPW_DEF-1:0] op;
  } stage_t;

endpackage

// File: rtl/fpsu_delay_line.sv
// One issue port's op delay line: DEPTH stages of {valid, xsub, op}
// and a count of valid entries currently travelling through it.
// Optional feature: FPSU_OPQ_FLUSH_EN enables the flush input; when the
// macro is undefined the flush input is accepted but has no effect.
module fpsu_delay_line
  import fpsu_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int OPW     = OPW_DEF,
  parameter int ADD_BIT = ADD_BIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_en,
  input  logic [OPW-1:0]   in_op,
  input  logic             in_xsub,
  input  logic             flush,
  output logic             addsel,
  output logic [OPW-1:0]   op_last,
  output logic [CNT_W-1:0] inflight
);

  logic           valid_q [DEPTH];
  logic           xsub_q  [DEPTH];
  logic [OPW-1:0] op_q    [DEPTH];
  logic [CNT_W-1:0] cnt_q;
  logic           kill;
  logic           leave;

`ifdef FPSU_OPQ_FLUSH_EN
  assign kill = flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign kill         = 1'b0;
`endif

  // an entry leaves the line when the last stage holds a valid op
  assign leave = valid_q[DEPTH-1];

  // stage 0 captures the issue; later stages shift, and a flush empties them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_q[k] <= 1'b0;
        xsub_q[k]  <= 1'b0;
        op_q[k]    <= '0;
      end
    end else begin
      valid_q[0] <= in_en;
      xsub_q[0]  <= in_en & in_xsub;
      op_q[0]    <= in_en ? in_op : '0;
      for (int k = 1; k < DEPTH; k++) begin
        valid_q[k] <= valid_q[k-1] & ~kill;
        xsub_q[k]  <= xsub_q[k-1] & ~kill;
        op_q[k]    <= kill ? '0 : op_q[k-1];
      end
    end
  end

  // occupancy: +1 on accept, -1 on leave, restarts from the new issue on flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (kill) begin
      cnt_q <= {{(CNT_W-1){1'b0}}, in_en};
    end else if (in_en && !leave) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end else if (!in_en && leave) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign addsel   = valid_q[DEPTH-1] & op_q[DEPTH-1][ADD_BIT] & ~xsub_q[DEPTH-1];
  assign op_last  = op_q[DEPTH-1];
  assign inflight = cnt_q;

endmodule

// File: rtl/fun_fpsu_opq.sv
// FP issue-port op queue: per-port op delay lines feeding the delayed
// add-select to the SIMD halves, plus a per-port merge of completion
// reports from the halves into a single completion strobe and word.
// Optional feature: FPSU_OPQ_FLUSH_EN enables per-port flush of in-flight ops.
//
// Completion handshake: hret_en is a one-cycle strobe per (half, port); a
// port completes in the cycle where the halves seen so far plus the halves
// strobing now cover half_mask. ret_en pulses combinationally in that cycle
// with ret carrying the OR of every word reported since the last completion.
module fun_fpsu_opq
  import fpsu_pkg::*;
#(
  parameter int NPORT   = NPORT_DEF,
  parameter int NHALF   = NHALF_DEF,
  parameter int OPW     = OPW_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ADD_BIT = ADD_BIT_DEF,
  parameter int RETW    = RETW_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NPORT-1:0]            in_en,
  input  logic [NPORT*OPW-1:0]        in_op,
  input  logic [NPORT-1:0]            in_xsub,
  input  logic [NPORT-1:0]            flush,
  input  logic [NHALF-1:0]            half_mask,
  input  logic [NHALF*NPORT*RETW-1:0] hret,
  input  logic [NHALF*NPORT-1:0]      hret_en,
  input  logic                        err_clr,
  output logic [NPORT-1:0]            addsel,
  output logic [NPORT*OPW-1:0]        op_last,
  output logic [NPORT*RETW-1:0]       ret,
  output logic [NPORT-1:0]            ret_en,
  output logic [NPORT*CNT_W-1:0]      inflight,
  output logic [NPORT-1:0]            err
);

  // per-port delay lines
  for (genvar p = 0; p < NPORT; p++) begin : g_port
    fpsu_delay_line #(
      .DEPTH   (DEPTH),
      .OPW     (OPW),
      .ADD_BIT (ADD_BIT)
    ) u_line (
      .clk      (clk),
      .rst      (rst),
      .in_en    (in_en[p]),
      .in_op    (in_op[p*OPW +: OPW]),
      .in_xsub  (in_xsub[p]),
      .flush    (flush[p]),
      .addsel   (addsel[p]),
      .op_last  (op_last[p*OPW +: OPW]),
      .inflight (inflight[p*CNT_W +: CNT_W])
    );
  end

  logic [NHALF-1:0] pend_q [NPORT];
  logic [RETW-1:0]  acc_q  [NPORT];
  logic [NPORT-1:0] err_q;

  logic [NHALF-1:0] cur_v  [NPORT];
  logic [RETW-1:0]  word_v [NPORT];
  logic [NHALF-1:0] pend_d [NPORT];
  logic [RETW-1:0]  acc_d  [NPORT];
  logic [NPORT-1:0] done_v;
  logic [NPORT-1:0] dup_v;
  logic [NPORT-1:0] err_d;
  logic             mask_on;

  // an all-zero mask means nobody is expected to report, so strobes are dropped
  assign mask_on = |half_mask;

  // gather this cycle's strobes, decide completion/duplicate, build next state and outputs
  always_comb begin
    ret    = '0;
    ret_en = '0;
    done_v = '0;
    dup_v  = '0;
    err_d  = '0;
    for (int p = 0; p < NPORT; p++) begin
      cur_v[p]  = '0;
      word_v[p] = '0;
      for (int h = 0; h < NHALF; h++) begin
        cur_v[p][h] = hret_en[h*NPORT+p];
        if (hret_en[h*NPORT+p]) begin
          word_v[p] = word_v[p] | hret[(h*NPORT+p)*RETW +: RETW];
        end
      end
      done_v[p] = mask_on & (((pend_q[p] | cur_v[p]) & half_mask) == half_mask);
      dup_v[p]  = mask_on & (|(pend_q[p] & cur_v[p]));
      pend_d[p] = pend_q[p];
      acc_d[p]  = acc_q[p];
      if (done_v[p]) begin
        pend_d[p] = '0;
        acc_d[p]  = '0;
      end else if (mask_on) begin
        pend_d[p] = pend_q[p] | cur_v[p];
        acc_d[p]  = acc_q[p] | word_v[p];
      end
      // a fresh duplicate wins over a coincident clear
      err_d[p]  = (err_q[p] & ~err_clr) | dup_v[p];
      ret_en[p] = rst & done_v[p];
      if (rst && done_v[p]) begin
        ret[p*RETW +: RETW] = acc_q[p] | word_v[p];
      end
    end
  end

  // merge state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < NPORT; p++) begin
        pend_q[p] <= '0;
        acc_q[p]  <= '0;
      end
      err_q <= '0;
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        pend_q[p] <= pend_d[p];
        acc_q[p]  <= acc_d[p];
      end
      err_q <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_fun_fpsu_opq.sv
// Bench for fun_fpsu_opq: directed vectors with hand-computed checks, plus
// a transaction-level model (list of issued ops with issue cycle, list of
// half reports since the last completion) compared against every output on
// every falling clock edge.
module tb_fun_fpsu_opq;

  localparam int NPORT   = 3;
  localparam int NHALF   = 2;
  localparam int OPW     = 21;
  localparam int DEPTH   = 3;
  localparam int ADD_BIT = 10;
  localparam int RETW    = 14;

`ifdef FPSU_OPQ_FLUSH_EN
  localparam bit FLUSH_ON = 1'b1;
`else
  localparam bit FLUSH_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NPORT-1:0]            in_en;
  logic [NPORT*OPW-1:0]        in_op;
  logic [NPORT-1:0]            in_xsub;
  logic [NPORT-1:0]            flush;
  logic [NHALF-1:0]            half_mask;
  logic [NHALF*NPORT*RETW-1:0] hret;
  logic [NHALF*NPORT-1:0]      hret_en;
  logic                        err_clr;
  logic [NPORT-1:0]            addsel;
  logic [NPORT*OPW-1:0]        op_last;
  logic [NPORT*RETW-1:0]       ret;
  logic [NPORT-1:0]            ret_en;
  logic [NPORT*4-1:0]          inflight;
  logic [NPORT-1:0]            err;

  fun_fpsu_opq #(
    .NPORT(NPORT), .NHALF(NHALF), .OPW(OPW), .DEPTH(DEPTH),
    .ADD_BIT(ADD_BIT), .RETW(RETW)
  ) dut (
    .clk(clk), .rst(rst), .in_en(in_en), .in_op(in_op), .in_xsub(in_xsub),
    .flush(flush), .half_mask(half_mask), .hret(hret), .hret_en(hret_en),
    .err_clr(err_clr), .addsel(addsel), .op_last(op_last), .ret(ret),
    .ret_en(ret_en), .inflight(inflight), .err(err)
  );

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int p, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s port=%0d got=%0h want=%0h t=%0t", name, p, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int             port;
    int             cyc;
    logic           xsub;
    logic [OPW-1:0] op;
  } op_rec_t;

  typedef struct {
    int              port;
    int              half;
    logic [RETW-1:0] word;
  } rep_rec_t;

  op_rec_t          fly[$];
  rep_rec_t         reps[$];
  logic [NPORT-1:0] m_err = '0;
  int               mcyc  = 0;

  // completion/duplicate view of port p given reports so far and current strobes
  task automatic model_merge(input int p, output logic done, output logic [RETW-1:0] word,
                             output logic dup);
    logic [NHALF-1:0] seen;
    seen = '0;
    word = '0;
    dup  = 1'b0;
    foreach (reps[i]) begin
      if (reps[i].port == p) begin
        seen[reps[i].half] = 1'b1;
        word = word | reps[i].word;
      end
    end
    for (int h = 0; h < NHALF; h++) begin
      if (hret_en[h*NPORT+p]) begin
        if (seen[h]) dup = 1'b1;
        seen[h] = 1'b1;
        word = word | hret[(h*NPORT+p)*RETW +: RETW];
      end
    end
    done = (half_mask != '0) && ((seen & half_mask) == half_mask);
    if (half_mask == '0) dup = 1'b0;
  endtask

  // advance the model on every rising edge
  always @(posedge clk) begin : model_step
    logic d, du;
    logic [RETW-1:0] w;
    logic [NPORT-1:0] ne;
    ne = '0;
    if (!rst) begin
      fly.delete();
      reps.delete();
      m_err = '0;
    end else begin
      for (int p = 0; p < NPORT; p++) begin
        model_merge(p, d, w, du);
        ne[p] = (m_err[p] & ~err_clr) | du;
        if (half_mask != '0) begin
          if (d) begin
            for (int i = reps.size() - 1; i >= 0; i--)
              if (reps[i].port == p) reps.delete(i);
          end else begin
            for (int h = 0; h < NHALF; h++)
              if (hret_en[h*NPORT+p])
                reps.push_back('{p, h, hret[(h*NPORT+p)*RETW +: RETW]});
          end
        end
      end
      m_err = ne;
      if (FLUSH_ON) begin
        for (int i = fly.size() - 1; i >= 0; i--)
          if (flush[fly[i].port]) fly.delete(i);
      end
      for (int p = 0; p < NPORT; p++)
        if (in_en[p]) fly.push_back('{p, mcyc, in_xsub[p], in_op[p*OPW +: OPW]});
    end
    mcyc++;
    for (int i = fly.size() - 1; i >= 0; i--)
      if (fly[i].cyc < mcyc - DEPTH) fly.delete(i);
  end

  // compare every output against the model on every falling edge
  always @(negedge clk) begin : compare
    logic ea, d, du, ee;
    logic [OPW-1:0] eo;
    logic [RETW-1:0] w, er;
    int n;
    for (int p = 0; p < NPORT; p++) begin
      ea = 1'b0;
      eo = '0;
      n  = 0;
      foreach (fly[i]) begin
        if (fly[i].port == p) begin
          n++;
          if (fly[i].cyc == mcyc - DEPTH) begin
            eo = fly[i].op;
            ea = fly[i].op[ADD_BIT] & ~fly[i].xsub;
          end
        end
      end
      model_merge(p, d, w, du);
      er = d ? w : '0;
      ee = m_err[p];
      if (!rst) begin
        ea = 1'b0; eo = '0; n = 0; d = 1'b0; er = '0; ee = 1'b0;
      end
      chk("m_addsel",   p, 32'(addsel[p]),                32'(ea));
      chk("m_op_last",  p, 32'(op_last[p*OPW +: OPW]),    32'(eo));
      chk("m_inflight", p, 32'(inflight[p*4 +: 4]),       32'(n));
      chk("m_ret_en",   p, 32'(ret_en[p]),                32'(d));
      chk("m_ret",      p, 32'(ret[p*RETW +: RETW]),      32'(er));
      chk("m_err",      p, 32'(err[p]),                   32'(ee));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic idle();
    in_en   = '0;
    in_op   = '0;
    in_xsub = '0;
    flush   = '0;
    hret    = '0;
    hret_en = '0;
    err_clr = 1'b0;
  endtask

  task automatic strobe(input int idx, input logic [RETW-1:0] w);
    hret_en[idx] = 1'b1;
    hret[idx*RETW +: RETW] = w;
  endtask

  // T2 stimulus: add bit and xsub per port per cycle, and addsel expected 3 cycles later
  logic [2:0] pa     [8] = '{3'b111, 3'b010, 3'b101, 3'b000, 3'b110, 3'b011, 3'b100, 3'b001};
  logic [2:0] px     [8] = '{3'b000, 3'b010, 3'b001, 3'b100, 3'b000, 3'b110, 3'b000, 3'b101};
  logic [2:0] exp_as [8] = '{3'b111, 3'b000, 3'b100, 3'b000, 3'b110, 3'b001, 3'b100, 3'b000};
  // T4 expected err[1] per relative cycle
  logic       exp_e1 [13] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [OPW-1:0] w;
    rst       = 1'b0;
    half_mask = 2'b11;
    idle();
    // reset state, with inputs active to show nothing leaks through
    in_en   = '1;
    hret_en = '1;
    at_neg();
    chk("rst_addsel",   0, 32'(addsel),   32'h0);
    chk("rst_inflight", 0, 32'(inflight), 32'h0);
    chk("rst_ret_en",   0, 32'(ret_en),   32'h0);
    chk("rst_err",      0, 32'(err),      32'h0);
    next_cyc();
    idle();
    next_cyc();
    rst = 1'b1;

    // T1: add op, xsub=0 -> addsel exactly 3 cycles later; then xsub=1 -> none
    in_en = 3'b001;
    in_op[OPW-1:0] = 21'h000400;
    for (int k = 1; k <= 4; k++) begin
      next_cyc();
      if (k == 1) idle();
      at_neg();
      chk("t1_addsel", 0, 32'(addsel[0]), 32'(k == 3));
      if (k == 3) chk("t1_op_last", 0, 32'(op_last[OPW-1:0]), 32'h000400);
    end
    in_en = 3'b001;
    in_op[OPW-1:0] = 21'h000401;
    in_xsub = 3'b001;
    for (int k = 1; k <= 4; k++) begin
      next_cyc();
      if (k == 1) idle();
      at_neg();
      chk("t1x_addsel", 0, 32'(addsel[0]), 32'h0);
      if (k == 3) chk("t1x_op_last", 0, 32'(op_last[OPW-1:0]), 32'h000401);
    end
    next_cyc();

    // T2: all ports issue for 8 cycles
    for (int i = 0; i <= 10; i++) begin
      idle();
      if (i < 8) begin
        in_en   = 3'b111;
        in_xsub = px[i];
        for (int p = 0; p < NPORT; p++) begin
          w = '0;
          w[ADD_BIT] = pa[i][p];
          w[5:0] = 6'(i*4 + p);
          in_op[p*OPW +: OPW] = w;
        end
      end
      at_neg();
      if (i >= 3 && i <= 8)
        for (int p = 0; p < NPORT; p++) chk("t2_inflight", p, 32'(inflight[p*4 +: 4]), 32'd3);
      if (i >= 3) chk("t2_addsel", 0, 32'(addsel), 32'(exp_as[i-3]));
      next_cyc();
    end

    // T3: two-half merge on port 0
    for (int r = 0; r <= 8; r++) begin
      idle();
      if (r == 5) strobe(0, 14'h0011);
      if (r == 7) strobe(NPORT + 0, 14'h0100);
      at_neg();
      chk("t3_ret_en", 0, 32'(ret_en[0]), 32'(r == 7));
      if (r == 7) chk("t3_ret", 0, 32'(ret[RETW-1:0]), 32'h0111);
      next_cyc();
    end

    // T4: duplicate report on port 1, sticky err, clear and clear-vs-new-error
    for (int r = 0; r <= 12; r++) begin
      idle();
      case (r)
        0: strobe(1, 14'h0003);
        1: strobe(1, 14'h0004);
        2: strobe(NPORT + 1, 14'h0010);
        5: err_clr = 1'b1;
        7: strobe(1, 14'h0001);
        8: begin strobe(1, 14'h0001); err_clr = 1'b1; end
        9: strobe(NPORT + 1, 14'h2000);
        11: err_clr = 1'b1;
        default: ;
      endcase
      at_neg();
      chk("t4_err", 1, 32'(err[1]), 32'(exp_e1[r]));
      chk("t4_ret_en", 1, 32'(ret_en[1]), 32'(r == 2 || r == 9));
      if (r == 2) chk("t4_ret_a", 1, 32'(ret[RETW +: RETW]), 32'h0017);
      if (r == 9) chk("t4_ret_b", 1, 32'(ret[RETW +: RETW]), 32'h2001);
      next_cyc();
    end

    // T5: half_mask=0 ignores strobes; they leave nothing pending afterwards
    for (int r = 0; r <= 4; r++) begin
      idle();
      half_mask = (r < 2) ? 2'b00 : 2'b11;
      if (r < 2) begin
        strobe(2, 14'h3fff);
        strobe(NPORT + 2, 14'h3fff);
      end
      if (r == 3) strobe(NPORT + 2, 14'h0020);
      if (r == 4) strobe(2, 14'h0001);
      at_neg();
      if (r < 2) chk("t5_ret_en_off", 2, 32'(ret_en), 32'h0);
      if (r == 1 || r == 2) chk("t5_err", 2, 32'(err[2]), 32'h0);
      if (r == 3) chk("t5_ret_en_part", 2, 32'(ret_en[2]), 32'h0);
      if (r == 4) begin
        chk("t5_ret_en_done", 2, 32'(ret_en[2]), 32'h1);
        chk("t5_ret", 2, 32'(ret[2*RETW +: RETW]), 32'h0021);
      end
      next_cyc();
    end

    // T6: two ops in flight on port 2, flush with a new issue in the same cycle
    for (int r = 0; r <= 6; r++) begin
      idle();
      if (r <= 2) begin
        in_en = 3'b100;
        in_op[2*OPW +: OPW] = 21'h000400 + 21'(2*r);
      end
      if (r == 2) flush = 3'b100;
      at_neg();
      if (r == 3) chk("t6_inflight", 2, 32'(inflight[8 +: 4]), FLUSH_ON ? 32'd1 : 32'd3);
      if (r == 3 || r == 4) chk("t6_addsel_old", 2, 32'(addsel[2]), FLUSH_ON ? 32'h0 : 32'h1);
      if (r == 5) begin
        chk("t6_addsel_new", 2, 32'(addsel[2]), 32'h1);
        chk("t6_op_last", 2, 32'(op_last[2*OPW +: OPW]), 32'h000404);
      end
      if (r == 6) chk("t6_addsel_end", 2, 32'(addsel[2]), 32'h0);
      next_cyc();
    end

    // T7: reset asserted mid-stream, then restart
    for (int r = 0; r <= 2; r++) begin
      idle();
      in_en = 3'b111;
      for (int p = 0; p < NPORT; p++) in_op[p*OPW +: OPW] = 21'h000400;
      if (r == 0) strobe(0, 14'h0001);
      if (r == 1) strobe(0, 14'h0002);
      at_neg();
      if (r == 2) begin
        chk("t7_err_pre", 0, 32'(err[0]), 32'h1);
        chk("t7_inflight_pre", 0, 32'(inflight[3:0]), 32'd2);
      end
      next_cyc();
    end
    strobe(0, 14'h0004);
    strobe(NPORT + 0, 14'h0008);
    #2;
    rst = 1'b0;
    #1;
    chk("t7_addsel",   0, 32'(addsel),   32'h0);
    chk("t7_op_last",  0, 32'(op_last),  32'h0);
    chk("t7_inflight", 0, 32'(inflight), 32'h0);
    chk("t7_err",      0, 32'(err),      32'h0);
    chk("t7_ret_en",   0, 32'(ret_en),   32'h0);
    chk("t7_ret",      0, 32'(ret),      32'h0);
    next_cyc();
    rst = 1'b1;
    idle();
    in_en = 3'b010;
    in_op[OPW +: OPW] = 21'h000400;
    for (int q = 0; q <= 4; q++) begin
      at_neg();
      chk("t7_restart_addsel", 1, 32'(addsel[1]), 32'(q == 3));
      next_cyc();
      if (q == 0) idle();
    end

    repeat (3) next_cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // hard stop in case the stimulus ever stalls
  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
